ballpark_seq: RTL and testbench
===============================

BALLPARK_SEQ -- requirements
Module: ballpark_seq

Interface
REQ-001 Parameter NUM_STAGES, default 5, number of fanout stages observed (bits of fanout_in).
REQ-002 Parameter LATENCY, default 2, cycles from d_out to a settled fanout_in.
REQ-003 Parameter CNT_W, default 8, width of pattern_len and err_count.
REQ-004 clock  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to run a test sequence; sampled only in IDLE.
REQ-007 pattern_len  input  CNT_W  number of d bits to drive; sampled with start.
REQ-008 d_out  output  1  stimulus driven to the fanout datapath d input.
REQ-009 fanout_in  input  NUM_STAGES  fanout datapath reduced outputs (fanout_test).
REQ-010 busy  output  1  high from the cycle after an accepted start until done.
REQ-011 done  output  1  one-cycle pulse at sequence end.
REQ-012 err_count  output  CNT_W  mismatching compare cycles in the last run, saturating.
REQ-013 pass  output  1  high when the last completed run had err_count == 0; valid from done until the next start.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE, DRAIN and DONE.
REQ-015 IDLE -> DRIVE on start with pattern_len != 0: latch pattern_len, clear err_count, clear pass, set busy.
REQ-016 IDLE -> DONE on start with pattern_len == 0: err_count = 0, pass = 1 at done.
REQ-017 In DRIVE, d_out SHALL present one pattern bit per cycle for exactly pattern_len cycles, then the FSM SHALL enter DRAIN.
REQ-018 Each driven bit SHALL enter a LATENCY-deep expected-value shift line with a valid flag.
REQ-019 Expected value per compare: stage bit i = delayed d when i is odd, 0 when i is even (XOR of i copies).
REQ-020 When the bit at the shift-line output is valid, the block SHALL compare fanout_in to the expected vector and increment err_count by 1 on any mismatch.
REQ-021 err_count SHALL saturate at 2^CNT_W-1.
REQ-022 DRAIN SHALL last exactly LATENCY cycles so that every driven bit is compared once, then go to DONE.
REQ-023 DONE SHALL last one cycle: done = 1, busy = 0, pass updated, then return to IDLE.
REQ-024 Outside DRIVE, d_out SHALL hold 0.
REQ-025 start while busy SHALL be ignored, with no effect on the current run.
REQ-026 start in the DONE cycle SHALL be ignored.
REQ-027 Total run length for pattern_len = N > 0: done asserts N+LATENCY+1 cycles after the start cycle.

Reset
REQ-028 While reset_n is low: FSM = IDLE, d_out = 0, busy = 0, done = 0, err_count = 0, pass = 0, shift-line valids cleared, pattern generator at seed.
REQ-029 Reset asserted mid-run SHALL abort the run immediately, with no done pulse.
REQ-030 The first start after reset_n deassertion SHALL be accepted normally.

Configuration
REQ-031 With BALLPARK_SEQ_LFSR_EN defined, pattern bits SHALL come from an 8-bit maximal LFSR, polynomial x^8+x^6+x^5+x^4+1, seed 8'h01, reloaded on each accepted start.
REQ-032 Without BALLPARK_SEQ_LFSR_EN, pattern bits SHALL alternate 1,0,1,0,..., starting with 1 on each run.

Structure
REQ-033 Package ballpark_pkg SHALL hold the FSM state enum, the LFSR seed/taps constants, and a function returning the expected-value mask for NUM_STAGES.
REQ-034 The pattern generator SHALL be sub-module ballpark_seq_pattern (enable, reload, bit out), containing the macro-selected logic.

Verification
REQ-035 Basic run: connect to a model of the fanout datapath, start with pattern_len = 8 -> done at cycle 11 after start, err_count = 0, pass = 1.
REQ-036 Injected fault: force fanout_in[1] = 0 with toggle pattern and pattern_len = 8 -> err_count = 4, pass = 0.
REQ-037 Saturation: CNT_W = 8, fanout_in[3] stuck at 1, LFSR build, pattern_len = 255 -> err_count equals the count of 0 pattern bits, with 255 never exceeded.
REQ-038 Zero-length and busy start: start with pattern_len = 0 -> done next cycle, pass = 1; then start (len 4) followed by start again at +2 cycles -> single run, done at +7.
REQ-039 Reset mid-run: drop reset_n 3 cycles into DRIVE -> all outputs 0 asynchronously, no done; a new start after release completes with err_count = 0.

Source files
------------

// File: rtl/ballpark_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ballpark_pkg
// Brief    : Shared types and constants for the ballpark_seq fanout tester:
//            FSM state encoding, LFSR seed/taps and expected-value mask.
// Revision : 1.0 - initial release
// ============================================================================
package ballpark_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // x^8 + x^6 + x^5 + x^4 + 1 : feedback taps on state bits 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'h01;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Stage i of the fanout datapath is the XOR of i copies of d, so odd
    // stages follow d and even stages are always 0.
    function automatic logic [31:0] expected_mask(input int unsigned num_stages);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            m[i] = (i < num_stages) && (i % 2 == 1);
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ballpark_seq_pattern.sv
`default_nettype none
// ============================================================================
// Module   : ballpark_seq_pattern
// Brief    : Pattern bit source for ballpark_seq. Default build produces an
//            alternating 1,0,1,0 stream; with BALLPARK_SEQ_LFSR_EN defined it
//            produces the output of an 8-bit maximal LFSR.
// Revision : 1.0 - initial release
// ============================================================================
module ballpark_seq_pattern
    import ballpark_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    input  logic reload,
    output logic bit_out
);

`ifdef BALLPARK_SEQ_LFSR_EN
    logic [7:0] r_lfsr;

    // Fibonacci LFSR, reloaded to the seed at the start of every run
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr <= LFSR_SEED;
        end else if (reload) begin
            r_lfsr <= LFSR_SEED;
        end else if (enable) begin
            r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & LFSR_TAPS)};
        end
    end

    assign bit_out = r_lfsr[7];
`else
    logic r_bit;

    // Toggle source; every run starts with a 1
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_bit <= 1'b1;
        end else if (reload) begin
            r_bit <= 1'b1;
        end else if (enable) begin
            r_bit <= ~r_bit;
        end
    end

    assign bit_out = r_bit;
`endif

endmodule
`default_nettype wire

// File: rtl/ballpark_seq.sv
`default_nettype none
// ============================================================================
// Module   : ballpark_seq
// Brief    : Test sequencer for a fanout datapath. Drives pattern_len
//            stimulus bits on d_out, compares the delayed fanout response
//            against the expected vector and reports a saturating error
//            count with a pass flag. Pattern source selected by
//            BALLPARK_SEQ_LFSR_EN (LFSR) or toggle (default).
// Revision : 1.0 - initial release
// ============================================================================
module ballpark_seq
    import ballpark_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int LATENCY    = 2,
    parameter int CNT_W      = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [CNT_W-1:0]      pattern_len,
    output logic                  d_out,
    input  logic [NUM_STAGES-1:0] fanout_in,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      err_count,
    output logic                  pass
);

    localparam logic [31:0]           C_MASK_FULL = expected_mask(NUM_STAGES);
    localparam logic [NUM_STAGES-1:0] C_MASK      = C_MASK_FULL[NUM_STAGES-1:0];
    localparam logic [CNT_W-1:0]      C_DRAIN_LEN = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0]      C_ONE       = CNT_W'(1);

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [LATENCY-1:0]  r_pipe_d;
    logic [LATENCY-1:0]  r_pipe_v;
    logic                w_accept;
    logic                w_pat_bit;
    logic                w_mismatch;
    logic [NUM_STAGES-1:0] w_expected;
    logic [CNT_W-1:0]    w_err_next;

    assign w_accept = (r_state == IDLE) && start;

    ballpark_seq_pattern u_pattern (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (r_state == DRIVE),
        .reload  (w_accept),
        .bit_out (w_pat_bit)
    );

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and decoded outputs
    always_comb begin
        w_next = r_state;
        d_out  = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (pattern_len == '0) ? DONE : DRIVE;
                end
            end
            DRIVE: begin
                d_out = w_pat_bit;
                busy  = 1'b1;
                if (r_cnt == C_ONE) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (r_cnt == C_ONE) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Remaining-cycle counter shared by DRIVE (pattern bits) and DRAIN (latency)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= pattern_len;
        end else if (r_state == DRIVE) begin
            r_cnt <= (r_cnt == C_ONE) ? C_DRAIN_LEN : r_cnt - C_ONE;
        end else if (r_state == DRAIN) begin
            r_cnt <= r_cnt - C_ONE;
        end
    end

    // Head of the expected-value line captures each driven bit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pipe_d[0] <= 1'b0;
            r_pipe_v[0] <= 1'b0;
        end else begin
            r_pipe_d[0] <= d_out;
            r_pipe_v[0] <= (r_state == DRIVE);
        end
    end

    generate
        for (genvar i = 1; i < LATENCY; i++) begin : g_pipe_stage
            // Delay stage matching the datapath latency
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_pipe_d[i] <= 1'b0;
                    r_pipe_v[i] <= 1'b0;
                end else begin
                    r_pipe_d[i] <= r_pipe_d[i-1];
                    r_pipe_v[i] <= r_pipe_v[i-1];
                end
            end
        end
    endgenerate

    assign w_expected = r_pipe_d[LATENCY-1] ? C_MASK : '0;
    assign w_mismatch = r_pipe_v[LATENCY-1] && (fanout_in != w_expected);

    // Saturating error count, cleared when a run is accepted
    always_comb begin
        w_err_next = err_count;
        if (w_accept) begin
            w_err_next = '0;
        end else if (w_mismatch && (err_count != '1)) begin
            w_err_next = err_count + C_ONE;
        end
    end

    // Error count and pass flag; pass settles on entry to DONE
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= '0;
            pass      <= 1'b0;
        end else begin
            err_count <= w_err_next;
            if ((w_next == DONE) && (r_state != DONE)) begin
                pass <= (w_err_next == '0);
            end else if (w_accept) begin
                pass <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ballpark_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ballpark_seq
// Brief    : Directed self-checking bench for ballpark_seq with a two-cycle
//            fanout datapath model and fault injection on its outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ballpark_seq;

    localparam int NS  = 5;
    localparam int LAT = 2;
    localparam int CW  = 8;

`ifdef BALLPARK_SEQ_LFSR_EN
    localparam int EXP_FAULT8 = 1;
    localparam int EXP_ERR_K4 = 0;
`else
    localparam int EXP_FAULT8 = 4;
    localparam int EXP_ERR_K4 = 1;
`endif

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] pattern_len = '0;
    logic          d_out;
    logic [NS-1:0] fanout_in;
    logic          busy;
    logic          done;
    logic [CW-1:0] err_count;
    logic          pass;

    logic [LAT-1:0] model_q = '0;
    logic [NS-1:0]  fault_and = 5'b11111;
    logic [NS-1:0]  fault_or  = 5'b00000;

    int tests = 0;
    int fails = 0;
    int cycles;
    int ones;
    int done_cnt;
    logic [7:0] dseq;

    always #5 clock = ~clock;

    // Fanout datapath model: odd stages follow d two cycles later
    always @(posedge clock) model_q <= {model_q[0], d_out};
    assign fanout_in = ((model_q[1] ? 5'b01010 : 5'b00000) & fault_and) | fault_or;

    ballpark_seq #(.NUM_STAGES(NS), .LATENCY(LAT), .CNT_W(CW)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .pattern_len (pattern_len),
        .d_out       (d_out),
        .fanout_in   (fanout_in),
        .busy        (busy),
        .done        (done),
        .err_count   (err_count),
        .pass        (pass)
    );

    task automatic run_seq(input logic [CW-1:0] len);
        logic got;
        got = 1'b0;
        @(negedge clock);
        start = 1'b1;
        pattern_len = len;
        cycles = 0;
        ones = 0;
        dseq = '0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clock);
            if (k == 1) start = 1'b0;
            if (d_out) ones++;
            if (k <= 8) dseq[k-1] = d_out;
            if (done) begin
                cycles = k;
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL run_timeout len=%0d: no done within 400 cycles", len);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        tests++;
        if ({d_out, busy, done, pass, err_count} !== 12'h000) begin
            fails++;
            $display("FAIL reset_outputs got=%h want=000", {d_out, busy, done, pass, err_count});
        end
        reset_n = 1'b1;
    endtask

    task automatic test_zero_len;
        run_seq(8'd0);
        tests++;
        if (cycles !== 1) begin fails++; $display("FAIL zero_len_cycles got=%0d want=1", cycles); end
        tests++;
        if (pass !== 1'b1 || err_count !== 8'd0) begin
            fails++; $display("FAIL zero_len_result pass=%b err=%0d want pass=1 err=0", pass, err_count);
        end
    endtask

    task automatic test_basic;
        run_seq(8'd8);
        tests++;
        if (cycles !== 11) begin fails++; $display("FAIL basic_cycles got=%0d want=11", cycles); end
        tests++;
        if (err_count !== 8'd0 || pass !== 1'b1) begin
            fails++; $display("FAIL basic_result err=%0d pass=%b want err=0 pass=1", err_count, pass);
        end
`ifndef BALLPARK_SEQ_LFSR_EN
        tests++;
        if (dseq !== 8'h55) begin fails++; $display("FAIL basic_pattern got=%h want=55", dseq); end
`endif
        @(negedge clock);
        tests++;
        if (done !== 1'b0 || pass !== 1'b1) begin
            fails++; $display("FAIL basic_after_done done=%b pass=%b want done=0 pass=1", done, pass);
        end
    endtask

    task automatic test_fault;
        fault_and = 5'b11101;
        run_seq(8'd8);
        tests++;
        if (err_count !== 8'(EXP_FAULT8) || pass !== 1'b0) begin
            fails++; $display("FAIL fault_stage1 err=%0d pass=%b want err=%0d pass=0", err_count, pass, EXP_FAULT8);
        end
        fault_and = 5'b11111;
    endtask

    task automatic test_saturation;
        fault_or = 5'b01000;
        run_seq(8'd255);
        tests++;
        if (cycles !== 258) begin fails++; $display("FAIL sat_cycles got=%0d want=258", cycles); end
        tests++;
        if (ones !== 128) begin fails++; $display("FAIL sat_ones got=%0d want=128", ones); end
        tests++;
        if (err_count !== 8'd127 || pass !== 1'b0) begin
            fails++; $display("FAIL sat_stuck3 err=%0d pass=%b want err=127 pass=0", err_count, pass);
        end
        fault_or = 5'b11111;
        run_seq(8'd255);
        tests++;
        if (err_count !== 8'd255) begin fails++; $display("FAIL sat_all err=%0d want=255", err_count); end
        fault_or = 5'b00000;
    endtask

    task automatic test_busy_start;
        int first_done;
        first_done = 0;
        done_cnt = 0;
        @(negedge clock);
        start = 1'b1;
        pattern_len = 8'd4;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (done) begin
                done_cnt++;
                if (first_done == 0) first_done = k;
            end
            if (k == 1) begin
                tests++;
                if (busy !== 1'b1) begin fails++; $display("FAIL busy_high got=%b want=1", busy); end
            end
            if (k == 8) begin
                tests++;
                if (busy !== 1'b0) begin fails++; $display("FAIL start_in_done busy=%b want=0", busy); end
            end
            start = (k == 2) || (k == 7);
            pattern_len = (k == 2) ? 8'd6 : 8'd4;
        end
        start = 1'b0;
        tests++;
        if (first_done !== 7 || done_cnt !== 1) begin
            fails++; $display("FAIL busy_start done_at=%0d pulses=%0d want done_at=7 pulses=1", first_done, done_cnt);
        end
        tests++;
        if (err_count !== 8'd0 || pass !== 1'b1) begin
            fails++; $display("FAIL busy_start_result err=%0d pass=%b want err=0 pass=1", err_count, pass);
        end
    endtask

    task automatic test_reset_midrun;
        fault_and = 5'b11101;
        done_cnt = 0;
        @(negedge clock);
        start = 1'b1;
        pattern_len = 8'd8;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            if (k == 1) start = 1'b0;
            if (done) done_cnt++;
        end
        tests++;
        if (err_count !== 8'(EXP_ERR_K4)) begin
            fails++; $display("FAIL midrun_err_before got=%0d want=%0d", err_count, EXP_ERR_K4);
        end
        reset_n = 1'b0;
        #1;
        tests++;
        if ({d_out, busy, done, pass, err_count} !== 12'h000) begin
            fails++; $display("FAIL midrun_async got=%h want=000", {d_out, busy, done, pass, err_count});
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (done) done_cnt++;
        end
        reset_n = 1'b1;
        fault_and = 5'b11111;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (done) done_cnt++;
        end
        tests++;
        if (done_cnt !== 0) begin fails++; $display("FAIL midrun_no_done pulses=%0d want=0", done_cnt); end
        run_seq(8'd8);
        tests++;
        if (cycles !== 11 || err_count !== 8'd0 || pass !== 1'b1) begin
            fails++; $display("FAIL midrun_rerun cycles=%0d err=%0d pass=%b want 11/0/1", cycles, err_count, pass);
        end
    endtask

    initial begin
        test_reset();
        test_zero_len();
        test_basic();
        test_fault();
        test_saturation();
        test_busy_start();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
